// File: rtl/mult_accumulator_if.sv
// Handshake and data bundle between the Booth multiplier environment and the
// multiply-accumulate back end.
interface mult_accumulator_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 2*WIDTH+8,
    parameter int CNT_WIDTH = 8
);
    logic                        op_valid;
    logic                        op_last;
    logic                        op_ready;
    logic signed [2*WIDTH-1:0]   product;
    logic signed [ACC_WIDTH-1:0] acc_out;
    logic [CNT_WIDTH-1:0]        term_count;
    logic                        overflow;
    logic                        out_valid;
    logic                        out_ready;

    modport master (
        output op_valid, op_last, product, out_ready,
        input  op_ready, acc_out, term_count, overflow, out_valid
    );

    modport slave (
        input  op_valid, op_last, product, out_ready,
        output op_ready, acc_out, term_count, overflow, out_valid
    );
endinterface

// File: rtl/mult_accumulator.sv
// Signed multiply-accumulate back end: tags accepted operand pairs, sums the
// matching multiplier products per frame and presents each frame total.
module mult_accumulator #(
    parameter int WIDTH     = 8,
    parameter int LATENCY   = WIDTH,
    parameter int ACC_WIDTH = 2*WIDTH+8,
    parameter int CNT_WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    mult_accumulator_if.slave bus
);
    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DRAIN  = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t                      state_r;
    logic                        op_ready_r;
    logic                        out_valid_r;
    logic [LATENCY-1:0]          tag_valid_r;
    logic [LATENCY-1:0]          tag_last_r;
    logic signed [ACC_WIDTH-1:0] acc_r;
    logic [CNT_WIDTH-1:0]        cnt_r;
    logic                        ovf_r;

    logic                        accept_s;
    logic                        tag_hit_s;
    logic                        handshake_s;
    logic signed [ACC_WIDTH-1:0] prod_ext_s;
    logic signed [ACC_WIDTH-1:0] sum_s;
    logic                        add_ovf_s;

    assign accept_s    = bus.op_valid & op_ready_r;
    assign tag_hit_s   = tag_valid_r[LATENCY-1];
    assign handshake_s = out_valid_r & bus.out_ready;

    assign bus.op_ready   = op_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.acc_out    = acc_r;
    assign bus.term_count = cnt_r;
    assign bus.overflow   = ovf_r;

    // Sign-extended product, wrapping sum and signed-overflow detection.
    always_comb begin
        prod_ext_s = ACC_WIDTH'(bus.product);
        sum_s      = acc_r + prod_ext_s;
        add_ovf_s  = 1'b0;
        if ((acc_r[ACC_WIDTH-1] == prod_ext_s[ACC_WIDTH-1]) &&
            (sum_s[ACC_WIDTH-1] != acc_r[ACC_WIDTH-1])) begin
            add_ovf_s = 1'b1;
        end else begin
            add_ovf_s = 1'b0;
        end
    end

    // Tag shift register: stage LATENCY-1 lines up with the product it tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_r <= {LATENCY{1'b0}};
            tag_last_r  <= {LATENCY{1'b0}};
        end else begin
            for (int i = 1; i < LATENCY; i++) begin
                tag_valid_r[i] <= tag_valid_r[i-1];
                tag_last_r[i]  <= tag_last_r[i-1];
            end
            tag_valid_r[0] <= accept_s;
            tag_last_r[0]  <= accept_s & bus.op_last;
        end
    end

    // Accumulator, saturating term counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {ACC_WIDTH{1'b0}};
            cnt_r <= {CNT_WIDTH{1'b0}};
            ovf_r <= 1'b0;
        end else if (handshake_s) begin
            acc_r <= {ACC_WIDTH{1'b0}};
            cnt_r <= {CNT_WIDTH{1'b0}};
            ovf_r <= 1'b0;
        end else if (tag_hit_s) begin
            acc_r <= sum_s;
            if (cnt_r != {CNT_WIDTH{1'b1}}) begin
                cnt_r <= cnt_r + CNT_WIDTH'(1'b1);
            end
            if (add_ovf_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Frame control FSM with registered op_ready / out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ACCUM;
            op_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (accept_s && bus.op_last) begin
                        state_r    <= DRAIN;
                        op_ready_r <= 1'b0;
                    end
                end
                DRAIN: begin
                    // In-flight earlier terms drain ahead of the tagged-last one.
                    if (tag_hit_s && tag_last_r[LATENCY-1]) begin
                        state_r     <= RESULT;
                        out_valid_r <= 1'b1;
                    end
                end
                RESULT: begin
                    if (handshake_s) begin
                        state_r     <= ACCUM;
                        out_valid_r <= 1'b0;
                        op_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ACCUM;
                    op_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_accumulator.sv
// Directed scoreboard bench for mult_accumulator with a behavioural
// LATENCY-deep multiplier model feeding the product input.
module tb_mult_accumulator;
    localparam int WIDTH     = 8;
    localparam int LATENCY   = 8;
    localparam int ACC_WIDTH = 16;
    localparam int CNT_WIDTH = 8;

    typedef struct {
        longint acc;
        longint cnt;
        longint ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    logic signed [WIDTH-1:0]   op_a;
    logic signed [WIDTH-1:0]   op_b;
    logic signed [2*WIDTH-1:0] mpipe [0:LATENCY-1];

    int   n_vec;
    int   n_miss;
    exp_t sb [$];
    exp_t e;

    mult_accumulator_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    mult_accumulator #(
        .WIDTH(WIDTH), .LATENCY(LATENCY), .ACC_WIDTH(ACC_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Multiplier model: free-running, not reset, product LATENCY cycles later.
    always @(posedge clk) begin
        mpipe[0] <= op_a * op_b;
        for (int i = 1; i < LATENCY; i++) mpipe[i] <= mpipe[i-1];
    end
    assign bus.product = mpipe[LATENCY-1];

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops and compares on every output handshake.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_result: got acc %0d with empty scoreboard", bus.acc_out);
            end else begin
                e = sb.pop_front();
                chk("sb_acc_out", bus.acc_out, e.acc);
                chk("sb_term_count", bus.term_count, e.cnt);
                chk("sb_overflow", bus.overflow, e.ovf);
            end
        end
    end

    task automatic expect_frame(input longint acc, input longint cnt, input longint ovf);
        exp_t x;
        x.acc = acc;
        x.cnt = cnt;
        x.ovf = ovf;
        sb.push_back(x);
    endtask

    // Called #1 after a posedge; returns #1 after the accepting edge.
    task automatic put(input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b,
                       input logic last);
        int n;
        n = 0;
        while (bus.op_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("op_ready_before_put", bus.op_ready, 1);
        bus.op_valid = 1'b1;
        bus.op_last  = last;
        op_a = a;
        op_b = b;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        bus.op_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    // From cycle t_last+1: out_valid must stay low LATENCY cycles, then rise.
    task automatic wait_result();
        for (int k = 1; k <= LATENCY; k++) begin
            chk("out_valid_early", bus.out_valid, 0);
            chk("op_ready_drain", bus.op_ready, 0);
            @(posedge clk); #1;
        end
        chk("out_valid_rise", bus.out_valid, 1);
        chk("op_ready_result", bus.op_ready, 0);
    endtask

    // Current cycle is the handshake cycle; check the cleared state after it.
    task automatic finish_handshake();
        @(posedge clk); #1;
        chk("op_ready_release", bus.op_ready, 1);
        chk("out_valid_clear", bus.out_valid, 0);
        chk("acc_clear", bus.acc_out, 0);
        chk("count_clear", bus.term_count, 0);
        chk("overflow_clear", bus.overflow, 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_miss);
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_miss = 0;
        rst_n = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_last = 1'b0;
        bus.out_ready = 1'b1;
        op_a = 8'sd0;
        op_b = 8'sd0;
        #22;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_op_ready", bus.op_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_acc_out", bus.acc_out, 0);
        chk("rst_term_count", bus.term_count, 0);
        chk("rst_overflow", bus.overflow, 0);

        // Three-term frame: 12 + 30 - 14 = 28.
        expect_frame(28, 3, 0);
        put(8'sd3, 8'sd4, 1'b0);
        put(8'sd5, 8'sd6, 1'b0);
        put(-8'sd2, 8'sd7, 1'b1);
        wait_result();
        finish_handshake();

        // Single-term frame: (-128)*(-128) = 16384.
        expect_frame(16384, 1, 0);
        put(-8'sd128, -8'sd128, 1'b1);
        wait_result();
        finish_handshake();

        // Back-pressure: 100 - 15 = 85 held while op_valid is asserted.
        bus.out_ready = 1'b0;
        expect_frame(85, 2, 0);
        put(8'sd10, 8'sd10, 1'b0);
        put(-8'sd3, 8'sd5, 1'b1);
        wait_result();
        bus.op_valid = 1'b1;
        bus.op_last = 1'b1;
        op_a = 8'sd9;
        op_b = 8'sd9;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_op_ready", bus.op_ready, 0);
            chk("bp_acc_out", bus.acc_out, 85);
            chk("bp_term_count", bus.term_count, 2);
        end
        bus.op_valid = 1'b0;
        bus.op_last = 1'b0;
        bus.out_ready = 1'b1;
        finish_handshake();
        expect_frame(5, 1, 0);
        put(8'sd1, 8'sd5, 1'b1);
        wait_result();
        finish_handshake();

        // 16-bit wrap: 4 * 16129 = 64516 -> -1020 with overflow.
        bus.out_ready = 1'b0;
        expect_frame(-1020, 4, 1);
        for (int k = 0; k < 4; k++) put(8'sd127, 8'sd127, (k == 3) ? 1'b1 : 1'b0);
        wait_result();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("ovf_held", bus.overflow, 1);
            chk("ovf_acc_held", bus.acc_out, -1020);
        end
        bus.out_ready = 1'b1;
        finish_handshake();

        // Asynchronous reset in DRAIN with three terms in flight.
        put(8'sd1, 8'sd1, 1'b0);
        put(8'sd2, 8'sd2, 1'b0);
        put(8'sd3, 8'sd3, 1'b1);
        @(posedge clk); #1;
        chk("drain_op_ready", bus.op_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_op_ready", bus.op_ready, 1);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_acc_out", bus.acc_out, 0);
        chk("arst_term_count", bus.term_count, 0);
        chk("arst_overflow", bus.overflow, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_frame(4, 1, 0);
        put(8'sd2, 8'sd2, 1'b1);
        wait_result();
        finish_handshake();

        // Interleaved op_valid: 1 + 4 + 9 = 14.
        expect_frame(14, 3, 0);
        put(8'sd1, 8'sd1, 1'b0);
        idle(1);
        put(8'sd2, 8'sd2, 1'b0);
        idle(1);
        put(8'sd3, 8'sd3, 1'b1);
        wait_result();
        finish_handshake();

        idle(3);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
